// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: UART state encoding and oversampling constants shared by rx and tx
package uart_rx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;
  localparam int OVERSAMPLE = 16;
  // width of a counter that indexes n items, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an idle-high asynchronous input
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // resets to the idle-high level so no false start is seen after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b11;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver with frame-error reporting
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_error
);
  localparam int BW = cnt_w(DATA_BITS);
  logic                 rx_s;
  state_t               state, state_n;
  logic [3:0]           tick, tick_n;
  logic [BW-1:0]        bits, bits_n;
  logic [DATA_BITS-1:0] shift, shift_n, data_n;
  logic                 done_n, ferr_n;

  sync_2ff u_sync (
    .clk  (i_clock),
    .rst_n(i_reset),
    .d    (i_rx),
    .q    (rx_s)
  );

  // next-state logic; counters only move on baud ticks, IDLE reacts to any low line
  always_comb begin
    state_n = state;
    tick_n  = tick;
    bits_n  = bits;
    shift_n = shift;
    data_n  = o_data;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE:
        if (!rx_s) begin
          state_n = START;
          tick_n  = '0;
        end
      START:
        if (i_tick) begin
          if (tick == 4'(OVERSAMPLE / 2 - 1)) begin
            state_n = rx_s ? IDLE : DATA;
            tick_n  = '0;
            bits_n  = '0;
          end else tick_n = tick + 4'd1;
        end
      DATA:
        if (i_tick) begin
          if (tick == 4'(OVERSAMPLE - 1)) begin
            shift_n = {rx_s, shift[DATA_BITS-1:1]};
            tick_n  = '0;
            if (bits == BW'(DATA_BITS - 1)) state_n = STOP;
            else bits_n = bits + BW'(1);
          end else tick_n = tick + 4'd1;
        end
      STOP:
        if (i_tick) begin
          if (tick == 4'(STOP_TICKS - 1)) begin
            state_n = IDLE;
            tick_n  = '0;
            done_n  = rx_s;
            ferr_n  = !rx_s;
            data_n  = rx_s ? shift : o_data;
          end else tick_n = tick + 4'd1;
        end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers; reset aborts any frame in progress
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state         <= IDLE;
      tick          <= '0;
      bits          <= '0;
      shift         <= '0;
      o_data        <= '0;
      o_rx_done     <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      state         <= state_n;
      tick          <= tick_n;
      bits          <= bits_n;
      shift         <= shift_n;
      o_data        <= data_n;
      o_rx_done     <= done_n;
      o_frame_error <= ferr_n;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 64 clocks per bit
module tb_uart_rx;
  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick  = 1'b0;
  logic       i_rx    = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done, o_frame_error;
  logic       tick_en = 1'b1;
  int         checks = 0, failures = 0, ndone = 0, nferr = 0;
  logic [8:0] sb[$];
  logic [7:0] last_good = 8'h00;
  logic [7:0] prev = 8'h00;

  uart_rx dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_tick       (i_tick),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_rx_done    (o_rx_done),
    .o_frame_error(o_frame_error)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one tick every 4 clocks, gated by tick_en
  initial begin
    int n = 0;
    forever begin
      @(negedge i_clock);
      n = (n + 1) % 4;
      i_tick = tick_en && (n == 0);
    end
  end

  // output monitor: pops the scoreboard on each pulse, checks data stability otherwise
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge i_clock);
      if (o_rx_done || o_frame_error) begin
        chk("exclusive", {31'd0, o_rx_done & o_frame_error}, 0);
        if (sb.size() == 0) chk("spurious_pulse", {30'd0, o_rx_done, o_frame_error}, 0);
        else begin
          e = sb.pop_front();
          chk(o_rx_done ? "done_kind" : "ferr_kind", {31'd0, o_frame_error}, {31'd0, e[8]});
          chk(o_rx_done ? "done_data" : "ferr_data_hold", {24'd0, o_data}, {24'd0, e[7:0]});
        end
        if (o_rx_done) ndone++;
        if (o_frame_error) nferr++;
      end else if (i_reset && o_data !== prev)
        chk("data_stable", {24'd0, o_data}, {24'd0, prev});
      prev = o_data;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  // sends one frame; gap_bit stalls ticks mid-bit, rst_bit resets mid-bit and aborts
  task automatic send(input logic [7:0] d, input logic stop, input int stop_len,
                      input int gap_bit, input int rst_bit);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    if (rst_bit < 0) begin
      sb.push_back({~stop, stop ? d : last_good});
      if (stop) last_good = d;
    end
    for (int b = 0; b < 10; b++) begin
      i_rx = fr[b];
      if (b == rst_bit + 1) begin
        hold(32);
        i_reset = 1'b0;
        #1;
        chk("rst_data", {24'd0, o_data}, 0);
        chk("rst_done", {31'd0, o_rx_done}, 0);
        chk("rst_ferr", {31'd0, o_frame_error}, 0);
        hold(10);
        i_rx = 1'b1;
        hold(2);
        i_reset = 1'b1;
        last_good = 8'h00;
        return;
      end
      if (b == gap_bit + 1) begin
        hold(32);
        tick_en = 1'b0;
        hold(100);
        tick_en = 1'b1;
        hold(32);
      end else hold(b == 9 ? stop_len : 64);
    end
    i_rx = 1'b1;
  endtask

  initial begin
    hold(3);
    chk("reset_data", {24'd0, o_data}, 0);
    chk("reset_done", {31'd0, o_rx_done}, 0);
    chk("reset_ferr", {31'd0, o_frame_error}, 0);
    i_reset = 1'b1;
    hold(200);
    send(8'h55, 1'b1, 64, -9, -9);
    hold(100);
    send(8'hA5, 1'b1, 64, -9, -9);
    send(8'h3C, 1'b1, 64, -9, -9);
    hold(100);
    i_rx = 1'b0;
    hold(16);
    i_rx = 1'b1;
    hold(200);
    chk("glitch_data", {24'd0, o_data}, {24'd0, last_good});
    send(8'hFF, 1'b0, 48, -9, -9);
    i_rx = 1'b1;
    hold(300);
    chk("ferr_data_kept", {24'd0, o_data}, 24'h3C);
    send(8'h96, 1'b1, 64, -9, 3);
    hold(200);
    send(8'h81, 1'b1, 64, -9, -9);
    hold(100);
    send(8'h00, 1'b1, 64, 4, -9);
    hold(300);
    chk("final_data", {24'd0, o_data}, 0);
    chk("sb_empty", sb.size(), 0);
    chk("done_count", ndone, 5);
    chk("ferr_count", nferr, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
